grant_bus_mux: RTL

- Downstream consumer of the 3-way grant arbiter: takes one-hot gnt_0/gnt_1/gnt_2 and gives the granted client the shared output bus for a fixed-length burst.
- Muxes three valid/ready client channels onto one bus, counts beats, and reports per-client burst completion or abort.
- Clients drop their req on done/abort, so the arbiter can move on.

---
 rtl/arb_pkg.sv | 40 ++++
 rtl/burst_counter.sv | 38 +++
 rtl/grant_bus_mux.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the grant arbiter and its downstream bus mux.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOCK    = 2'b01,
        XFER    = 2'b10,
        RELEASE = 2'b11
    } state_t;

    // Owner codes match the arbiter's grant-state encoding
    typedef logic [1:0] owner_t;
    localparam owner_t OWN_NONE = 2'b00;
    localparam owner_t OWN_0    = 2'b01;
    localparam owner_t OWN_1    = 2'b10;
    localparam owner_t OWN_2    = 2'b11;

    // Grants should be one-hot; if not, the lowest index wins
    function automatic owner_t gnt_to_owner(input logic g0, input logic g1, input logic g2);
        owner_t o;
        if (g0)      o = OWN_0;
        else if (g1) o = OWN_1;
        else if (g2) o = OWN_2;
        else         o = OWN_NONE;
        return o;
    endfunction

    // One-hot client select for an owner code (bit 0 = client 0)
    function automatic logic [2:0] owner_onehot(input owner_t o);
        logic [2:0] oh;
        case (o)
            OWN_0:   oh = 3'b001;
            OWN_1:   oh = 3'b010;
            OWN_2:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/burst_counter.sv
// Beat counter for one burst; flags the final beat index.
module burst_counter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             beat,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear wins; the FSM leaves XFER on the final beat, the
    // all-ones hold only keeps BURST_LEN == 2**CNT_W from wrapping to 0
    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (beat && (count_q != CNT_MAX))
            count_d = count_q + 1'b1;
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
    assign last  = (count_q == LAST_IDX);

endmodule

// File: rtl/grant_bus_mux.sv
// Gives the arbiter-granted client the shared bus for one fixed-length burst.
module grant_bus_mux
    import arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic              gnt_2,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic              valid_0,
    input  logic              valid_1,
    input  logic              valid_2,
    output logic              ready_0,
    output logic              ready_1,
    output logic              ready_2,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [1:0]        owner,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              done_0,
    output logic              done_1,
    output logic              done_2,
    output logic              abort,
    output logic              busy
);

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [2:0] done_q, done_d;
    logic       abort_q, abort_d;

    logic       owner_gnt;
    logic       beat;
    logic       last;
    logic       cnt_clear;

    // Grant of the latched owner, used to detect a mid-burst withdrawal
    always_comb begin
        owner_gnt = 1'b0;
        case (owner_q)
            OWN_0:   owner_gnt = gnt_0;
            OWN_1:   owner_gnt = gnt_1;
            OWN_2:   owner_gnt = gnt_2;
            default: owner_gnt = 1'b0;
        endcase
    end

    // Bus mux: only the owner is connected, and only while transferring
    always_comb begin
        bus_data  = '0;
        bus_valid = 1'b0;
        ready_0   = 1'b0;
        ready_1   = 1'b0;
        ready_2   = 1'b0;
        if (state_q == XFER) begin
            case (owner_q)
                OWN_0: begin bus_data = data_0; bus_valid = valid_0; ready_0 = bus_ready; end
                OWN_1: begin bus_data = data_1; bus_valid = valid_1; ready_1 = bus_ready; end
                OWN_2: begin bus_data = data_2; bus_valid = valid_2; ready_2 = bus_ready; end
                default: ;
            endcase
        end
    end

    assign beat      = bus_valid & bus_ready;
    assign cnt_clear = (state_q == LOCK) || (state_q == RELEASE);

    burst_counter #(
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .beat  (beat),
        .count (beat_cnt),
        .last  (last)
    );

    // Next state, owner latch and completion/abort pulses
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        done_d  = 3'b000;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_0 || gnt_1 || gnt_2) begin
                    owner_d = gnt_to_owner(gnt_0, gnt_1, gnt_2);
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (!owner_gnt) begin
                    state_d = RELEASE;
                    abort_d = 1'b1;
                end else begin
                    state_d = XFER;
                end
            end
            XFER: begin
                // A final beat completes even if the grant drops with it
                if (beat && last) begin
                    state_d = RELEASE;
                    done_d  = owner_onehot(owner_q);
                end else if (!owner_gnt) begin
                    state_d = RELEASE;
                    abort_d = 1'b1;
                end
            end
            RELEASE: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
        endcase
    end

    // State and pulse registers; reset silently drops any burst in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            done_q  <= 3'b000;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign owner  = owner_q;
    assign done_0 = done_q[0];
    assign done_1 = done_q[1];
    assign done_2 = done_q[2];
    assign abort  = abort_q;
    assign busy   = (state_q == LOCK) || (state_q == XFER);

endmodule
